// File: rtl/alu_reg_file.sv
// alu_reg_file: register file and flag register sitting in front of the ALU.
// Two combinational read ports feed in_a/in_b. One synchronous write port takes the ALU result.
// A 3-bit flag register captures the ALU flags {overflow, negative, zero}.
// Optional macro ALU_REG_FILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module alu_reg_file #(
   parameter  int BW    = 16,
   parameter  int NREGS = 8,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [BW-1:0] wr_data,
   input  logic [AW-1:0] rd_a_addr,
   input  logic [AW-1:0] rd_b_addr,
   output logic [BW-1:0] rd_a,
   output logic [BW-1:0] rd_b,
   input  logic          flags_en,
   input  logic [2:0]    flags_in,
   output logic [2:0]    flags_q
);

   logic [BW-1:0] mem [NREGS];
   logic          wr_in_range;
   logic          rd_a_in_range;
   logic          rd_b_in_range;

   // Address decode; with a power-of-two NREGS these are constant true.
   always_comb begin
      wr_in_range   = int'(wr_addr)   < NREGS;
      rd_a_in_range = int'(rd_a_addr) < NREGS;
      rd_b_in_range = int'(rd_b_addr) < NREGS;
   end

   // Register array: reset clears every entry; writes to unmapped addresses are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en && wr_in_range) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Flag register: loads independently of register writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= 3'b000;
      end else if (flags_en) begin
         flags_q <= flags_in;
      end
   end

   // Read ports: stored contents, unmapped addresses read zero, optional write forwarding.
   always_comb begin
      rd_a = '0;
      rd_b = '0;
      if (rd_a_in_range) begin
         rd_a = mem[rd_a_addr];
      end
      if (rd_b_in_range) begin
         rd_b = mem[rd_b_addr];
      end
`ifdef ALU_REG_FILE_BYPASS_EN
      if (wr_en && !rst && wr_in_range && (rd_a_addr == wr_addr)) begin
         rd_a = wr_data;
      end
      if (wr_en && !rst && wr_in_range && (rd_b_addr == wr_addr)) begin
         rd_b = wr_data;
      end
`endif
   end

endmodule

// File: tb/tb_alu_reg_file.sv
// Directed bench for alu_reg_file, with a behavioural model checked on every falling edge.
module tb_alu_reg_file;

   localparam int BW = 16;
   localparam int NREGS = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [BW-1:0] wr_data;
   logic [AW-1:0] rd_a_addr;
   logic [AW-1:0] rd_b_addr;
   logic [BW-1:0] rd_a;
   logic [BW-1:0] rd_b;
   logic          flags_en;
   logic [2:0]    flags_in;
   logic [2:0]    flags_q;

   int n_checks = 0;
   int n_fail   = 0;

   logic [BW-1:0] model_mem [NREGS];
   logic [2:0]    model_flags;
   bit            model_valid = 1'b0;

   alu_reg_file #(.BW(BW), .NREGS(NREGS)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_a_addr (rd_a_addr),
      .rd_b_addr (rd_b_addr),
      .rd_a      (rd_a),
      .rd_b      (rd_b),
      .flags_en  (flags_en),
      .flags_in  (flags_in),
      .flags_q   (flags_q)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Expected read value: what the register holds, or the in-flight write data when forwarding is built in.
   function automatic logic [BW-1:0] model_read(input logic [AW-1:0] addr);
      logic [BW-1:0] v;
      v = (int'(addr) < NREGS) ? model_mem[addr] : '0;
`ifdef ALU_REG_FILE_BYPASS_EN
      if (wr_en === 1'b1 && rst === 1'b0 && int'(wr_addr) < NREGS && addr == wr_addr) v = wr_data;
`endif
      return v;
   endfunction

   // Model state update on each rising edge.
   always @(posedge clk) begin
      if (rst === 1'b1) begin
         for (int i = 0; i < NREGS; i++) model_mem[i] = '0;
         model_flags = 3'b000;
         model_valid = 1'b1;
      end else begin
         if (wr_en === 1'b1 && int'(wr_addr) < NREGS) model_mem[wr_addr] = wr_data;
         if (flags_en === 1'b1) model_flags = flags_in;
      end
   end

   // Every-cycle compare against the model.
   always @(negedge clk) begin
      if (model_valid) begin
         check("model_rd_a", rd_a, model_read(rd_a_addr));
         check("model_rd_b", rd_b, model_read(rd_b_addr));
         check("model_flags", {13'd0, flags_q}, {13'd0, model_flags});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [BW-1:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   logic [BW-1:0] alu_sum;
   logic [2:0]    alu_flags;

   initial begin
      rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
      rd_a_addr = 3'd0; rd_b_addr = 3'd0; flags_en = 1'b0; flags_in = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; wr_en = 1'b0; rd_a_addr = 3'd3;
      @(negedge clk);
      check("reset_write_discarded", rd_a, 16'h0000);
      check("reset_flags", {13'd0, flags_q}, 16'h0000);

      wr(3'd3, 16'h1234);
      wr(3'd5, 16'h8001);
      rd_a_addr = 3'd3; rd_b_addr = 3'd5;
      @(negedge clk);
      check("dual_read_a", rd_a, 16'h1234);
      check("dual_read_b_negative", rd_b, 16'h8001);

      wr(3'd7, 16'h7FFF);
      rd_a_addr = 3'd7; rd_b_addr = 3'd7;
      @(negedge clk);
      check("same_addr_a", rd_a, 16'h7FFF);
      check("same_addr_b", rd_b, 16'h7FFF);
      wr(3'd7, 16'hFFFF);
      @(negedge clk);
      check("overwrite_a", rd_a, 16'hFFFF);
      check("overwrite_b", rd_b, 16'hFFFF);
      rd_a_addr = 3'd3; rd_b_addr = 3'd5;
      @(negedge clk);
      check("others_kept_3", rd_a, 16'h1234);
      check("others_kept_5", rd_b, 16'h8001);

      wr(3'd2, 16'h0011);
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h00AA; rd_a_addr = 3'd2;
      @(negedge clk);
`ifdef ALU_REG_FILE_BYPASS_EN
      check("rdw_same_cycle", rd_a, 16'h00AA);
`else
      check("rdw_same_cycle", rd_a, 16'h0011);
`endif
      tick();
      wr_en = 1'b0;
      @(negedge clk);
      check("rdw_next_cycle", rd_a, 16'h00AA);

      flags_en = 1'b1; flags_in = 3'b110;
      tick();
      flags_en = 1'b0; flags_in = 3'b001;
      @(negedge clk);
      check("flags_load", {13'd0, flags_q}, 16'h0006);
      tick();
      @(negedge clk);
      check("flags_hold", {13'd0, flags_q}, 16'h0006);
      rst = 1'b1; flags_en = 1'b1; flags_in = 3'b101;
      tick();
      rst = 1'b0; flags_en = 1'b0;
      @(negedge clk);
      check("flags_reset_priority", {13'd0, flags_q}, 16'h0000);
      check("mem_reset", rd_a, 16'h0000);

      wr(3'd1, 16'h4321);
      wr_en = 1'b0; wr_addr = 3'd1; wr_data = 16'hDEAD; flags_in = 3'bxxx; rd_a_addr = 3'd1;
      repeat (5) tick();
      wr_addr = 3'bxxx; wr_data = 16'hxxxx;
      tick();
      @(negedge clk);
      check("wr_en_gating", rd_a, 16'h4321);
      check("flags_x_safe", {13'd0, flags_q}, 16'h0000);
      flags_in = 3'b000; wr_addr = 3'd0; wr_data = 16'h0000;

      wr(3'd4, 16'h7FFF);
      wr(3'd6, 16'h0001);
      rd_a_addr = 3'd4; rd_b_addr = 3'd6;
      #1;
      alu_sum = rd_a + rd_b;
      alu_flags[2] = (rd_a[15] == rd_b[15]) && (alu_sum[15] != rd_a[15]);
      alu_flags[1] = alu_sum[15];
      alu_flags[0] = (alu_sum == '0);
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = alu_sum;
      flags_en = 1'b1; flags_in = alu_flags;
      tick();
      wr_en = 1'b0; flags_en = 1'b0; rd_a_addr = 3'd0;
      @(negedge clk);
      check("loopback_result", rd_a, 16'h8000);
      check("loopback_flags", {13'd0, flags_q}, 16'h0006);

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
